// File: rtl/picorv_mem_bridge.sv
// picorv_mem_bridge: PicoRV32 native bus to 1-cycle registered word RAM bridge
module picorv_mem_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          AW        = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_valid,
    input  logic          mem_instr,
    input  logic [31:0]   mem_addr,
    input  logic [31:0]   mem_wdata,
    input  logic [3:0]    mem_wstrb,
    output logic          mem_ready,
    output logic [31:0]   mem_rdata,
    output logic          bus_err,
    output logic          ram_wen,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata
);
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
    state_t      state, state_n;
    logic        ready_n, err_n;
    logic [31:0] rdata_n, merge, merge_n;
    logic        hit;
    logic        unused;
    assign unused    = &{1'b0, mem_instr, mem_addr[1:0]};
    assign hit       = mem_addr[31:AW+2] == BASE_ADDR[31:AW+2];
    assign ram_addr  = mem_addr[AW+1:2];
    assign ram_wen   = state == WR;
    assign ram_wdata = merge;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mem_ready <= 1'b0;
            bus_err   <= 1'b0;
            mem_rdata <= '0;
            merge     <= '0;
        end else begin
            state     <= state_n;
            mem_ready <= ready_n;
            bus_err   <= err_n;
            mem_rdata <= rdata_n;
            merge     <= merge_n;
        end
    end
    always_comb begin
        state_n = state;
        ready_n = 1'b0;
        err_n   = 1'b0;
        rdata_n = mem_rdata;
        merge_n = merge;
        case (state)
            IDLE: if (mem_valid) begin
                if (!hit) begin
                    state_n = RESP;
                    ready_n = 1'b1;
                    err_n   = 1'b1;
                    rdata_n = '0;
                end else if (mem_wstrb == 4'hF) begin
                    state_n = WR;
                    merge_n = mem_wdata;
                end else begin
                    state_n = RD;
                end
            end
            // partial writes pass through RD to capture the old word for the merge
            RD: if (mem_wstrb == 4'h0) begin
                state_n = RESP;
                ready_n = 1'b1;
                rdata_n = ram_rdata;
            end else begin
                state_n = WR;
                for (int i = 0; i < 4; i++)
                    merge_n[8*i +: 8] = mem_wstrb[i] ? mem_wdata[8*i +: 8] : ram_rdata[8*i +: 8];
            end
            WR: begin
                state_n = RESP;
                ready_n = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: doc/picorv_mem_bridge.md
Name: picorv_mem_bridge

Overview:
- Bridges the PicoRV32 native memory interface (valid/ready, byte write strobes) to a single-port, word-wide, 1-cycle-registered-read on-chip RAM/ROM.
- Port set on the RAM side: wen, addr, wdata, rdata.
- Decodes one address window and implements byte-lane writes by read-modify-write, since the RAM accepts full-word writes only.
- Sits between the CPU core and the firmware memory.

Parameters:
- BASE_ADDR, 32'h0000_0000: byte address of window start; must be aligned to 4*2^AW.
- AW, 8: RAM word-address width; the window is 4*2^AW bytes (default 1 KiB, 256 words).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_valid  in  1  CPU request valid; held until mem_ready.
- mem_instr  in  1  instruction fetch flag; informational, no effect on behaviour.
- mem_addr  in  32  byte address; held stable while mem_valid.
- mem_wdata  in  32  write data.
- mem_wstrb  in  4  byte write strobes; 0 = read.
- mem_ready  out  1  one-cycle completion pulse, registered.
- mem_rdata  out  32  read data, registered; valid while mem_ready=1.
- bus_err  out  1  one-cycle pulse with mem_ready when the address is outside the window.
- ram_wen  out  1  RAM write enable.
- ram_addr  out  AW  RAM word address.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data, registered inside the RAM, 1-cycle latency.

Behaviour:
- Reset (async): state=IDLE; mem_ready=0, bus_err=0, mem_rdata=0, merge register=0. ram_wen=0 immediately.
- ram_addr = mem_addr[AW+1:2] combinationally at all times. The RAM therefore samples the address in the acceptance cycle.
- hit = (mem_addr[31:AW+2] == BASE_ADDR[31:AW+2]). mem_addr[1:0] is ignored.
- ram_wen = (state==WR). ram_wdata = merge register.

FSM states: IDLE, RD, WR, RESP.
- IDLE, mem_valid=0: stay in IDLE.
- IDLE, mem_valid=1, !hit: go to RESP; set mem_ready<=1, bus_err<=1, mem_rdata<=0. No RAM write.
- IDLE, hit, wstrb==0 (read): go to RD.
- IDLE, hit, wstrb==4'hF (full write): merge<=mem_wdata; go to WR.
- IDLE, hit, other nonzero wstrb (partial write): go to RD, which captures the old word.
- RD, read: mem_rdata<=ram_rdata; mem_ready<=1; go to RESP.
- RD, partial write: per lane i, merge byte i = wstrb[i] ? mem_wdata byte i : ram_rdata byte i; go to WR.
- WR: ram_wen=1 for exactly one cycle; mem_ready<=1; go to RESP.
- RESP: mem_ready=1 (and bus_err if set) for exactly one cycle; both cleared at the next edge; return to IDLE. The request is not resampled in RESP.

Latency, counted as cycles from the acceptance edge to the mem_ready-high cycle:
- read: mem_ready high 2 cycles after acceptance.
- full write: 2 cycles.
- partial write: 3 cycles.
- miss: 1 cycle.

Other rules:
- mem_rdata is unchanged by hit writes. It holds its last value until the next read or miss.
- A new request seen in IDLE the cycle after RESP is accepted; back-to-back transactions are supported.
- mem_valid dropped mid-transaction is a protocol violation. The transaction still completes, including the RAM write.
- rst asserted mid-transaction aborts it. The RAM write is suppressed unless the WR edge has already occurred. No mem_ready is produced.
- Exactly one ram_wen cycle per hit write; zero for reads and misses.

Test Plan:
- Preload RAM word 5 = 32'hAABBCCDD; read addr 32'h14 -> mem_ready exactly one cycle, 2 cycles after acceptance, mem_rdata=32'hAABBCCDD, bus_err=0, ram_wen never high.
- Full write 32'h12345678 to 32'h20 with wstrb=F, then read 32'h20 -> one ram_wen cycle at ram_addr=8, ram_wdata=32'h12345678; the read returns 32'h12345678.
- Word 5 = 32'hAABBCCDD; write wdata=32'h11223344, wstrb=4'b0101 -> ram_wdata=32'hAA22CC44; mem_ready 3 cycles after acceptance; a read-back returns 32'hAA22CC44.
- Read 32'h0000_0400 with default params -> mem_ready and bus_err high together 1 cycle after acceptance; mem_rdata=0; no ram_wen; RAM contents unchanged.
- Back-to-back: read 32'h14, then write wstrb=4'b1000 to 32'h18 in the cycle after RESP -> both complete, each with a single mem_ready pulse, correct data, and no lost or duplicated RAM write.
- Assert rst during the RD state of a partial write -> mem_ready, bus_err and ram_wen go 0 immediately; the RAM word is unchanged; the next read completes normally.
